// File: rtl/labs_energy_source_pkg.sv
//------------------------------------------------------------------------------
// labs_energy_source_pkg : shared FSM encodings, datapath width helpers and the
//                          energy sentinel for the LABS energy source.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package labs_energy_source_pkg;

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_COMPUTE = 2'd1;
  localparam logic [1:0] c_ST_EMIT    = 2'd2;

  localparam int c_E_WIDTH_DEF = 20;
  localparam logic [c_E_WIDTH_DEF-1:0] c_E_SENTINEL = '1;

  // Signed C_k width: |C_k| <= N-1 always fits clog2(N) magnitude bits
  function automatic int ck_width(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int sq_width(input int n);
    return 2 * $clog2(n);
  endfunction

  function automatic int lag_width(input int n);
    return $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/labs_energy_source_if.sv
//------------------------------------------------------------------------------
// labs_energy_source_if : range command and (seq, e, valid) result bundle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface labs_energy_source_if #(
  parameter int SEQ_WIDTH = 8,
  parameter int E_WIDTH   = 20
);
  logic                 i_start;
  logic [SEQ_WIDTH-1:0] i_seq_first;
  logic [SEQ_WIDTH-1:0] i_seq_last;
  logic [SEQ_WIDTH-1:0] o_seq;
  logic [E_WIDTH-1:0]   o_e;
  logic                 o_valid;
  logic                 o_busy;
  logic                 o_done;

  modport master (
    output i_start, i_seq_first, i_seq_last,
    input  o_seq, o_e, o_valid, o_busy, o_done
  );

  modport slave (
    input  i_start, i_seq_first, i_seq_last,
    output o_seq, o_e, o_valid, o_busy, o_done
  );
endinterface

`default_nettype wire

// File: rtl/labs_autocorr_lag.sv
//------------------------------------------------------------------------------
// labs_autocorr_lag : combinational signed aperiodic autocorrelation C_k of one
//                     lag k for an N-bit sequence (bit 0 -> +1, bit 1 -> -1).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module labs_autocorr_lag
  import labs_energy_source_pkg::*;
#(
  parameter int SEQ_WIDTH = 8
) (
  input  logic [SEQ_WIDTH-1:0]                   i_seq,
  input  logic [lag_width(SEQ_WIDTH)-1:0]        i_k,
  output logic signed [ck_width(SEQ_WIDTH)-1:0]  o_ck
);

  localparam int CW = ck_width(SEQ_WIDTH);

  logic [SEQ_WIDTH-1:0] w_mask;
  logic [SEQ_WIDTH-1:0] w_diff;
  logic [CW-1:0]        w_span;
  logic [CW-1:0]        w_pop;

  // Differing pairs each contribute -1 instead of +1, hence span - 2*pop;
  // the modular subtraction lands on the correct two's-complement value.
  always_comb begin
    w_mask = {SEQ_WIDTH{1'b1}} >> i_k;
    w_diff = (i_seq ^ (i_seq >> i_k)) & w_mask;
    w_span = CW'(SEQ_WIDTH) - CW'(i_k);
    w_pop  = '0;
    for (int i = 0; i < SEQ_WIDTH; i++) begin
      w_pop = w_pop + CW'(w_diff[i]);
    end
    o_ck = signed'(w_span - (w_pop << 1));
  end

endmodule

`default_nettype wire

// File: rtl/labs_energy_source.sv
//------------------------------------------------------------------------------
// labs_energy_source : enumerates a sequence range and streams each candidate's
//                      LABS energy, one lag per clock. Optional macro
//                      LABS_SYMMETRY_SKIP_EN skips candidates with MSB set.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module labs_energy_source
  import labs_energy_source_pkg::*;
#(
  parameter int SEQ_WIDTH = 8,
  parameter int E_WIDTH   = 20
) (
  input  logic                clk,
  input  logic                rst,
  labs_energy_source_if.slave bus
);

  localparam int CW   = ck_width(SEQ_WIDTH);
  localparam int SW   = sq_width(SEQ_WIDTH);
  localparam int KW   = lag_width(SEQ_WIDTH);
  localparam int AW   = E_WIDTH + 1;
  localparam int SUMW = ((AW > SW) ? AW : SW) + 1;

  localparam logic [KW-1:0]      c_K_FIRST    = KW'(1);
  localparam logic [KW-1:0]      c_K_LAST     = KW'(SEQ_WIDTH - 1);
  localparam logic [E_WIDTH-1:0] c_E_ALL_ONES = '1;

`ifdef LABS_SYMMETRY_SKIP_EN
  localparam logic c_SKIP_EN = 1'b1;
`else
  localparam logic c_SKIP_EN = 1'b0;
`endif

  logic [1:0]           r_state;
  logic [KW-1:0]        r_k;
  logic [AW-1:0]        r_acc;
  logic [SEQ_WIDTH-1:0] r_cur;
  logic [SEQ_WIDTH-1:0] r_last;
  logic [SEQ_WIDTH-1:0] r_seq;
  logic [E_WIDTH-1:0]   r_e;
  logic                 r_valid;
  logic                 r_done;

  logic signed [CW-1:0] w_ck;
  logic [CW-1:0]        w_mag;
  logic [SW-1:0]        w_sq;
  logic [SUMW-1:0]      w_sum;
  logic [AW-1:0]        w_acc_next;
  logic [E_WIDTH-1:0]   w_e_sat;
  logic                 w_skip;

  labs_autocorr_lag #(
    .SEQ_WIDTH (SEQ_WIDTH)
  ) u_lag (
    .i_seq (r_cur),
    .i_k   (r_k),
    .o_ck  (w_ck)
  );

  assign w_mag = w_ck[CW-1] ? $unsigned(-w_ck) : $unsigned(w_ck);
  assign w_sq  = SW'(w_mag) * SW'(w_mag);
  assign w_sum = SUMW'(r_acc) + SUMW'(w_sq);

  // Once bit E_WIDTH is set the sum is parked there, so it can never wrap.
  assign w_acc_next = (w_sum[SUMW-1:E_WIDTH] != '0) ? (AW'(1) << E_WIDTH)
                                                    : w_sum[AW-1:0];
  assign w_e_sat    = r_acc[E_WIDTH] ? c_E_ALL_ONES : r_acc[E_WIDTH-1:0];
  assign w_skip     = c_SKIP_EN & r_cur[SEQ_WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
      r_k     <= '0;
      r_acc   <= '0;
      r_cur   <= '0;
      r_last  <= '0;
      r_seq   <= '0;
      r_e     <= c_E_ALL_ONES;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (bus.i_start) begin
            r_cur  <= bus.i_seq_first;
            r_last <= bus.i_seq_last;
            if (bus.i_seq_first > bus.i_seq_last) begin
              r_done <= 1'b1;
            end else begin
              r_state <= c_ST_COMPUTE;
              r_k     <= c_K_FIRST;
              r_acc   <= '0;
            end
          end
        end

        c_ST_COMPUTE: begin
          if (w_skip) begin
            // Complement duplicate: burn one cycle, never emit
            if (r_cur == r_last) begin
              r_done  <= 1'b1;
              r_state <= c_ST_IDLE;
            end else begin
              r_cur <= r_cur + SEQ_WIDTH'(1);
              r_k   <= c_K_FIRST;
              r_acc <= '0;
            end
          end else begin
            r_acc <= w_acc_next;
            if (r_k == c_K_LAST) begin
              r_state <= c_ST_EMIT;
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
        end

        c_ST_EMIT: begin
          r_valid <= 1'b1;
          r_seq   <= r_cur;
          r_e     <= w_e_sat;
          // Compare before increment so an all-ones last never wraps
          if (r_cur == r_last) begin
            r_done  <= 1'b1;
            r_state <= c_ST_IDLE;
          end else begin
            r_cur   <= r_cur + SEQ_WIDTH'(1);
            r_k     <= c_K_FIRST;
            r_acc   <= '0;
            r_state <= c_ST_COMPUTE;
          end
        end

        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign bus.o_seq   = r_seq;
  assign bus.o_e     = r_e;
  assign bus.o_valid = r_valid;
  assign bus.o_done  = r_done;
  assign bus.o_busy  = (r_state != c_ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_labs_energy_source.sv
//------------------------------------------------------------------------------
// tb_labs_energy_source : randomized self-checking bench for labs_energy_source
//                         (N=4) plus a narrow-E_WIDTH instance for saturation.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_labs_energy_source;

  localparam int N   = 4;
  localparam int EW  = 20;
  localparam int EWS = 3;
  localparam int SAT = (1 << EWS) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start   = 1'b0;
  logic [N-1:0] first_v = '0;
  logic [N-1:0] last_v  = '0;

  labs_energy_source_if #(.SEQ_WIDTH(N), .E_WIDTH(EW))  bus ();
  labs_energy_source_if #(.SEQ_WIDTH(N), .E_WIDTH(EWS)) sbus ();

  assign bus.i_start      = start;
  assign bus.i_seq_first  = first_v;
  assign bus.i_seq_last   = last_v;
  assign sbus.i_start     = start;
  assign sbus.i_seq_first = first_v;
  assign sbus.i_seq_last  = last_v;

  labs_energy_source #(.SEQ_WIDTH(N), .E_WIDTH(EW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  labs_energy_source #(.SEQ_WIDTH(N), .E_WIDTH(EWS)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  int checks = 0;
  int errors = 0;

  int hold_seq = 0;
  int hold_e   = (1 << EW) - 1;
  int hold_es  = SAT;

  // Reference energy straight from the +/-1 definition
  function automatic int energy(input int s);
    int e;
    int c;
    e = 0;
    for (int k = 1; k < N; k++) begin
      c = 0;
      for (int i = 0; i + k < N; i++) begin
        c += ((((s >> i) & 1) == 1) ? -1 : 1) * ((((s >> (i + k)) & 1) == 1) ? -1 : 1);
      end
      e += c * c;
    end
    return e;
  endfunction

  function automatic bit skipped(input int s);
`ifdef LABS_SYMMETRY_SKIP_EN
    return ((s >> (N - 1)) & 1) == 1;
`else
    return 1'b0;
`endif
  endfunction

  // Runs one range; cycle index j counts edges after the start-sampling edge.
  task automatic run_range(input string name, input int f, input int l,
                           input int restart_at, input int abort_at);
    int ev_t[$];
    int ev_s[$];
    int t;
    int t_end;
    int idx;
    bit ev;
    bit ok_range;
    t        = 0;
    idx      = 0;
    ok_range = (f <= l);
    if (ok_range) begin
      for (int c = f; c <= l; c++) begin
        if (skipped(c)) begin
          t += 1;
        end else begin
          t += N;
          ev_t.push_back(t);
          ev_s.push_back(c);
        end
      end
    end
    t_end = t;

    start   = 1'b1;
    first_v = N'(f);
    last_v  = N'(l);
    @(posedge clk);
    #1;
    start = 1'b0;

    for (int j = 0; j <= t_end; j++) begin
      if (j == abort_at) begin
        rst = 1'b1;
        #1;
        checks += 5;
        if (bus.o_seq !== '0 || bus.o_e !== {EW{1'b1}} || bus.o_valid !== 1'b0 ||
            bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
          errors++;
          $display("FAIL %s async_reset got seq=%0d e=%0d v=%b b=%b d=%b exp 0,%0d,0,0,0",
                   name, bus.o_seq, bus.o_e, bus.o_valid, bus.o_busy, bus.o_done, (1 << EW) - 1);
        end
        checks++;
        if (sbus.o_e !== SAT[EWS-1:0] || sbus.o_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s async_reset_sat got e=%0d v=%b exp %0d,0", name, sbus.o_e, sbus.o_valid, SAT);
        end
        hold_seq = 0;
        hold_e   = (1 << EW) - 1;
        hold_es  = SAT;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        return;
      end

      ev = (idx < ev_t.size()) && (ev_t[idx] == j);
      if (ev) begin
        hold_seq = ev_s[idx];
        hold_e   = energy(ev_s[idx]);
        hold_es  = (hold_e >= SAT) ? SAT : hold_e;
        idx++;
      end

      checks++;
      if (bus.o_valid !== ev) begin
        errors++;
        $display("FAIL %s valid j=%0d got %b exp %b", name, j, bus.o_valid, ev);
      end
      checks++;
      if (bus.o_done !== (j == t_end)) begin
        errors++;
        $display("FAIL %s done j=%0d got %b exp %b", name, j, bus.o_done, (j == t_end));
      end
      checks++;
      if (bus.o_busy !== (ok_range && j < t_end)) begin
        errors++;
        $display("FAIL %s busy j=%0d got %b exp %b", name, j, bus.o_busy, (ok_range && j < t_end));
      end
      checks++;
      if (bus.o_seq !== N'(hold_seq)) begin
        errors++;
        $display("FAIL %s seq j=%0d got %0d exp %0d", name, j, bus.o_seq, hold_seq);
      end
      checks++;
      if (bus.o_e !== EW'(hold_e)) begin
        errors++;
        $display("FAIL %s e j=%0d got %0d exp %0d", name, j, bus.o_e, hold_e);
      end
      checks++;
      if (sbus.o_valid !== ev || sbus.o_e !== EWS'(hold_es)) begin
        errors++;
        $display("FAIL %s sat j=%0d got v=%b e=%0d exp v=%b e=%0d",
                 name, j, sbus.o_valid, sbus.o_e, ev, hold_es);
      end

      if (j == restart_at) begin
        start   = 1'b1;
        first_v = N'(l + 1);
        last_v  = N'(f);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;

    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s quiet_after got v=%b d=%b b=%b exp 0,0,0",
               name, bus.o_valid, bus.o_done, bus.o_busy);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.o_seq !== '0 || bus.o_e !== {EW{1'b1}} || bus.o_valid !== 1'b0 ||
        bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset got seq=%0d e=%0d v=%b b=%b d=%b exp 0,%0d,0,0,0",
               bus.o_seq, bus.o_e, bus.o_valid, bus.o_busy, bus.o_done, (1 << EW) - 1);
    end
    checks++;
    if (sbus.o_e !== SAT[EWS-1:0]) begin
      errors++;
      $display("FAIL reset_sat e got %0d exp %0d", sbus.o_e, SAT);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    run_range("basic_0_3", 0, 3, -1, -1);
  endtask

  task automatic test_empty();
    run_range("empty_5_2", 5, 2, -1, -1);
  endtask

  task automatic test_top_end();
    run_range("top_15_15", 15, 15, -1, -1);
    // Idle cycles afterwards must not produce a wrapped candidate
    repeat (2 * N) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_seq !== N'(15)) begin
        errors++;
        $display("FAIL top_nowrap got v=%b seq=%0d exp 0,15", bus.o_valid, bus.o_seq);
      end
    end
  endtask

  task automatic test_restart_ignored();
    run_range("restart_ignored", 0, 3, N + 1, -1);
  endtask

  task automatic test_reset_mid();
    run_range("reset_mid", 0, 3, -1, 2 * N + 1);
    run_range("after_reset_0_0", 0, 0, -1, -1);
  endtask

  task automatic test_symmetry();
    run_range("sym_6_9", 6, 9, -1, -1);
  endtask

  task automatic test_back_to_back();
    int f;
    int l;
    for (int it = 0; it < 10; it++) begin
      f = $urandom_range(0, 15);
      if ($urandom_range(0, 4) == 0) begin
        l = $urandom_range(0, 15);
      end else begin
        l = f + $urandom_range(0, 3);
        if (l > 15) l = 15;
      end
      run_range("random", f, l, -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_top_end();
    test_restart_ignored();
    test_reset_mid();
    test_symmetry();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
